load_store_unit: RTL and testbench

Pipeline-side front end for the word-addressed data `memory`. It accepts one byte-addressed load or store at a time from the MEM stage and converts it to word index, byte lanes and, for sub-word stores, a read-modify-write sequence. It drives the `memory` write/address/data inputs, consumes its combinational read data and `err_invalid_address`, and returns extended load data plus error flags.

---
 rtl/load_store_unit_if.sv | 39 +++
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 tb/tb_load_store_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bus bundle between the MEM stage, the load/store unit and the word-addressed memory.
// The unit uses the slave modport; the pipeline/memory side uses master.
interface load_store_unit_if #(
   parameter int WORD_SIZE = 32
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [1:0]           req_size;
   logic                 req_signed;
   logic [WORD_SIZE-1:0] req_address;
   logic [WORD_SIZE-1:0] req_wdata;

   logic                 resp_valid;
   logic [WORD_SIZE-1:0] resp_data;
   logic                 resp_err_misaligned;
   logic                 resp_err_address;

   logic                 mem_write_enabled;
   logic                 mem_read_enabled;
   logic [WORD_SIZE-1:0] mem_address;
   logic [WORD_SIZE-1:0] mem_input_data;
   logic [WORD_SIZE-1:0] mem_output_data;
   logic                 mem_err_invalid_address;

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_address, req_wdata,
      input  mem_output_data, mem_err_invalid_address,
      output req_ready, resp_valid, resp_data, resp_err_misaligned, resp_err_address,
      output mem_write_enabled, mem_read_enabled, mem_address, mem_input_data
   );

   modport master (
      output req_valid, req_write, req_size, req_signed, req_address, req_wdata,
      output mem_output_data, mem_err_invalid_address,
      input  req_ready, resp_valid, resp_data, resp_err_misaligned, resp_err_address,
      input  mem_write_enabled, mem_read_enabled, mem_address, mem_input_data
   );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed, big-endian load/store front end for a word-addressed memory.
// Sub-word stores are done as read-modify-write; memory commits on the WRITE cycle's falling edge.
module load_store_unit #(
   parameter int WORD_SIZE   = 32,
   parameter int MEMORY_SIZE = 1024
) (
   input  logic               clock,
   input  logic               reset_n,
   load_store_unit_if.slave   bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;
   localparam logic [WORD_SIZE-1:0] MEM_WORDS = WORD_SIZE'(MEMORY_SIZE);

   state_t               state_reg;
   state_t               state_next;

   logic                 write_reg;
   logic [1:0]           size_reg;
   logic                 signed_reg;
   logic [WORD_SIZE-1:0] address_reg;
   logic [WORD_SIZE-1:0] data_reg;
   logic                 err_mis_reg;
   logic                 err_addr_reg;

   logic                 accept;
   logic [1:0]           size_eff;
   logic                 req_misaligned;
   logic                 req_out_of_range;

   logic [3:0]           lane_en;
   logic [WORD_SIZE-1:0] store_lanes;
   logic [WORD_SIZE-1:0] merged_word;
   logic [7:0]           load_byte;
   logic [15:0]          load_half;
   logic [WORD_SIZE-1:0] load_word;

   // Classification of the live request; only consulted on the accept edge.
   assign accept           = bus.req_valid && (state_reg == IDLE);
   assign size_eff         = (bus.req_size == 2'd3) ? SIZE_WORD : bus.req_size;
   assign req_misaligned   = ((size_eff == SIZE_HALF) && bus.req_address[0]) ||
                             ((size_eff == SIZE_WORD) && (bus.req_address[1:0] != 2'd0));
   assign req_out_of_range = (bus.req_address >> 2) >= MEM_WORDS;

   // Lane gi holds bits [gi*8+7:gi*8], i.e. big-endian byte offset 3-gi.
   assign store_lanes = (size_reg == SIZE_BYTE) ? {4{data_reg[7:0]}} : {2{data_reg[15:0]}};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_en[gi] = (size_reg == SIZE_BYTE) ? (address_reg[1:0] == 2'(3 - gi)) :
                              (size_reg == SIZE_HALF) ? (address_reg[1] == (gi < 2)) : 1'b1;
         assign merged_word[gi*8 +: 8] = lane_en[gi] ? store_lanes[gi*8 +: 8]
                                                     : bus.mem_output_data[gi*8 +: 8];
      end
   endgenerate

   always_comb begin
      load_byte = 8'h00;
      case (address_reg[1:0])
         2'd0:    load_byte = bus.mem_output_data[31:24];
         2'd1:    load_byte = bus.mem_output_data[23:16];
         2'd2:    load_byte = bus.mem_output_data[15:8];
         default: load_byte = bus.mem_output_data[7:0];
      endcase
      load_half = address_reg[1] ? bus.mem_output_data[15:0] : bus.mem_output_data[31:16];
      case (size_reg)
         SIZE_BYTE: load_word = {{24{signed_reg & load_byte[7]}}, load_byte};
         SIZE_HALF: load_word = {{16{signed_reg & load_half[15]}}, load_half};
         default:   load_word = bus.mem_output_data;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // data_reg carries the store data until READ, then the merged word or the load result.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         write_reg    <= 1'b0;
         size_reg     <= SIZE_BYTE;
         signed_reg   <= 1'b0;
         address_reg  <= '0;
         data_reg     <= '0;
         err_mis_reg  <= 1'b0;
         err_addr_reg <= 1'b0;
      end else begin
         if (accept) begin
            write_reg    <= bus.req_write;
            size_reg     <= size_eff;
            signed_reg   <= bus.req_signed;
            address_reg  <= bus.req_address;
            data_reg     <= bus.req_wdata;
            err_mis_reg  <= req_misaligned;
            err_addr_reg <= !req_misaligned && req_out_of_range;
         end else if (state_reg == READ) begin
            err_addr_reg <= err_addr_reg | bus.mem_err_invalid_address;
            data_reg     <= write_reg ? merged_word : load_word;
         end
      end
   end

   always_comb begin
      state_next              = state_reg;
      bus.req_ready           = 1'b0;
      bus.resp_valid          = 1'b0;
      bus.resp_data           = '0;
      bus.resp_err_misaligned = 1'b0;
      bus.resp_err_address    = 1'b0;
      bus.mem_write_enabled   = 1'b0;
      bus.mem_read_enabled    = 1'b0;
      bus.mem_address         = '0;
      bus.mem_input_data      = '0;
      case (state_reg)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (accept) begin
               if (req_misaligned || req_out_of_range) begin
                  state_next = RESP;
               end else if (bus.req_write && (size_eff == SIZE_WORD)) begin
                  state_next = WRITE;
               end else begin
                  state_next = READ;
               end
            end
         end
         READ: begin
            bus.mem_read_enabled = 1'b1;
            bus.mem_address      = {2'b00, address_reg[WORD_SIZE-1:2]};
            if (write_reg && !bus.mem_err_invalid_address) begin
               state_next = WRITE;
            end else begin
               state_next = RESP;
            end
         end
         WRITE: begin
            bus.mem_write_enabled = 1'b1;
            bus.mem_address       = {2'b00, address_reg[WORD_SIZE-1:2]};
            bus.mem_input_data    = data_reg;
            state_next            = RESP;
         end
         RESP: begin
            bus.resp_valid          = 1'b1;
            bus.resp_err_misaligned = err_mis_reg;
            bus.resp_err_address    = err_addr_reg;
            if (!write_reg && !err_mis_reg && !err_addr_reg) begin
               bus.resp_data = data_reg;
            end
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model predicts per-cycle outputs,
// a bench-side memory plays the attached word memory.
module tb_load_store_unit;
   localparam int MEM_WORDS = 1024;

   typedef struct packed {
      logic [31:0] data;
      logic        mis;
      logic        ae;
   } resp_t;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic force_err = 1'b0;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   logic [31:0] dev_mem [0:MEM_WORDS-1];
   logic [31:0] ref_mem [0:MEM_WORDS-1];

   resp_t       exp_resp [int];
   logic [63:0] exp_wr   [int];
   logic [31:0] exp_rd   [int];
   bit          exp_busy [int];

   load_store_unit_if #(.WORD_SIZE(32)) bus ();

   load_store_unit #(.WORD_SIZE(32), .MEMORY_SIZE(MEM_WORDS)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Attached memory: combinational read, commit on the falling edge.
   assign bus.mem_output_data = (bus.mem_address < 32'(MEM_WORDS)) ? dev_mem[bus.mem_address[9:0]] : 32'h0;
   assign bus.mem_err_invalid_address = force_err || (bus.mem_address >= 32'(MEM_WORDS));
   always @(negedge clock) begin
      if (bus.mem_write_enabled && (bus.mem_address < 32'(MEM_WORDS)))
         dev_mem[bus.mem_address[9:0]] = bus.mem_input_data;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Spec-level model of one request: latency, response, memory traffic.
   task automatic model(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic inj,
                        output int lat, output resp_t r, output logic rd, output logic dw,
                        output logic [31:0] widx, output logic [31:0] wdat);
      int s   = (sz == 2'd3) ? 2 : int'(sz);
      int off = int'(a % 4);
      int idx = int'(a / 4);
      logic [31:0] old;
      int sh;
      longint v;
      logic [31:0] mask;
      r    = '0;
      rd   = 1'b0;
      dw   = 1'b0;
      widx = a / 4;
      wdat = 32'h0;
      r.mis = (s == 1 && off % 2 != 0) || (s == 2 && off != 0);
      r.ae  = !r.mis && (a / 4 >= 32'(MEM_WORDS));
      if (r.mis || r.ae) begin
         lat = 1;
      end else if (!w) begin
         lat = 2;
         rd  = 1'b1;
         if (inj) begin
            r.ae = 1'b1;
         end else begin
            old = ref_mem[idx];
            if (s == 0) begin
               v = longint'((old >> (8 * (3 - off))) & 32'hFF);
               if (sg && v > 127) v = v - 256;
            end else if (s == 1) begin
               v = longint'((old >> ((off >= 2) ? 0 : 16)) & 32'hFFFF);
               if (sg && v > 32767) v = v - 65536;
            end else begin
               v = longint'(old);
            end
            r.data = 32'(v);
         end
      end else if (s == 2) begin
         lat  = 2;
         dw   = 1'b1;
         wdat = wd;
         ref_mem[idx] = wd;
      end else begin
         rd = 1'b1;
         if (inj) begin
            lat  = 2;
            r.ae = 1'b1;
         end else begin
            lat  = 3;
            dw   = 1'b1;
            old  = ref_mem[idx];
            sh   = (s == 0) ? 8 * (3 - off) : ((off >= 2) ? 0 : 16);
            mask = ((s == 0) ? 32'hFF : 32'hFFFF) << sh;
            wdat = (old & ~mask) | ((wd << sh) & mask);
            ref_mem[idx] = wdat;
         end
      end
   endtask

   // Called at #1 after an edge with the DUT idle; returns at #1 after the edge where it is idle again.
   task automatic issue(input string name, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic inj,
                        input logic pin, input logic [31:0] lit);
      int e0 = cyc + 1;
      int lat;
      resp_t r;
      logic rd, dw;
      logic [31:0] widx, wdat;
      model(w, sz, sg, a, wd, inj, lat, r, rd, dw, widx, wdat);
      if (pin) chk({name, " model"}, r.data, lit);
      for (int k = e0; k < e0 + lat; k++) exp_busy[k] = 1'b1;
      exp_resp[e0 + lat - 1] = r;
      if (dw) exp_wr[e0 + lat - 2] = {widx, wdat};
      if (rd) exp_rd[e0] = widx;
      force_err       = inj;
      bus.req_write   = w;
      bus.req_size    = sz;
      bus.req_signed  = sg;
      bus.req_address = a;
      bus.req_wdata   = wd;
      bus.req_valid   = 1'b1;
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      repeat (lat) begin @(posedge clock); #1; end
      force_err = 1'b0;
      $display("txn %-10s addr=%08h wdata=%08h -> data=%08h mis=%0b ae=%0b lat=%0d",
               name, a, wd, r.data, r.mis, r.ae, lat);
   endtask

   // Per-cycle comparison against the model's schedule.
   initial begin
      forever begin
         @(posedge clock); #1;
         chk("req_ready", 32'(bus.req_ready), 32'(!exp_busy.exists(cyc)));
         chk("resp_valid", 32'(bus.resp_valid), 32'(exp_resp.exists(cyc)));
         if (exp_resp.exists(cyc)) begin
            chk("resp_data", bus.resp_data, exp_resp[cyc].data);
            chk("resp_err_misaligned", 32'(bus.resp_err_misaligned), 32'(exp_resp[cyc].mis));
            chk("resp_err_address", 32'(bus.resp_err_address), 32'(exp_resp[cyc].ae));
         end
         chk("mem_write_enabled", 32'(bus.mem_write_enabled), 32'(exp_wr.exists(cyc)));
         if (exp_wr.exists(cyc)) begin
            chk("write mem_address", bus.mem_address, exp_wr[cyc][63:32]);
            chk("mem_input_data", bus.mem_input_data, exp_wr[cyc][31:0]);
         end
         chk("mem_read_enabled", 32'(bus.mem_read_enabled), 32'(exp_rd.exists(cyc)));
         if (exp_rd.exists(cyc)) chk("read mem_address", bus.mem_address, exp_rd[cyc]);
      end
   end

   initial begin
      int c;
      for (int i = 0; i < MEM_WORDS; i++) begin
         dev_mem[i] = 32'(i) * 32'h9E3779B1;
         ref_mem[i] = 32'(i) * 32'h9E3779B1;
      end
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
      bus.req_signed = 1'b0; bus.req_address = 32'h0; bus.req_wdata = 32'h0;

      #2;
      chk("reset req_ready", 32'(bus.req_ready), 32'd1);
      chk("reset resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("reset resp_data", bus.resp_data, 32'd0);
      chk("reset err_mis", 32'(bus.resp_err_misaligned), 32'd0);
      chk("reset err_addr", 32'(bus.resp_err_address), 32'd0);
      chk("reset mem_we", 32'(bus.mem_write_enabled), 32'd0);
      chk("reset mem_re", 32'(bus.mem_read_enabled), 32'd0);
      chk("reset mem_address", bus.mem_address, 32'd0);
      chk("reset mem_input_data", bus.mem_input_data, 32'd0);
      repeat (2) @(posedge clock);
      #3 reset_n = 1'b1;
      @(posedge clock); #1;

      //          name        w     sz    sg    addr          wdata         inj   pin   literal
      issue("SW",        1'b1, 2'd2, 1'b0, 32'h10,   32'h8899AABB, 1'b0, 1'b0, 32'h0);
      issue("LBU",       1'b0, 2'd0, 1'b0, 32'h10,   32'h0,        1'b0, 1'b1, 32'h00000088);
      issue("LB",        1'b0, 2'd0, 1'b1, 32'h10,   32'h0,        1'b0, 1'b1, 32'hFFFFFF88);
      issue("LB3",       1'b0, 2'd0, 1'b1, 32'h13,   32'h0,        1'b0, 1'b1, 32'hFFFFFFBB);
      issue("LHU",       1'b0, 2'd1, 1'b0, 32'h12,   32'h0,        1'b0, 1'b1, 32'h0000AABB);
      issue("LH",        1'b0, 2'd1, 1'b1, 32'h10,   32'h0,        1'b0, 1'b1, 32'hFFFF8899);
      issue("LW",        1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b0, 1'b1, 32'h8899AABB);
      issue("SB",        1'b1, 2'd0, 1'b0, 32'h11,   32'h000000CC, 1'b0, 1'b0, 32'h0);
      issue("LW-SB",     1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b0, 1'b1, 32'h88CCAABB);
      issue("SH",        1'b1, 2'd1, 1'b0, 32'h12,   32'h00001234, 1'b0, 1'b0, 32'h0);
      issue("LW-SH",     1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b0, 1'b1, 32'h88CC1234);
      issue("LW-size3",  1'b0, 2'd3, 1'b1, 32'h10,   32'h0,        1'b0, 1'b1, 32'h88CC1234);
      issue("LW-mis",    1'b0, 2'd2, 1'b0, 32'h12,   32'h0,        1'b0, 1'b0, 32'h0);
      issue("LH-mis",    1'b0, 2'd1, 1'b1, 32'h11,   32'h0,        1'b0, 1'b0, 32'h0);
      issue("SW-mis",    1'b1, 2'd2, 1'b0, 32'h13,   32'h12345678, 1'b0, 1'b0, 32'h0);
      issue("LW-top",    1'b0, 2'd2, 1'b0, 32'hFFC,  32'h0,        1'b0, 1'b0, 32'h0);
      issue("LW-oor",    1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,        1'b0, 1'b0, 32'h0);
      issue("SB-oor",    1'b1, 2'd0, 1'b0, 32'h1001, 32'h000000EE, 1'b0, 1'b0, 32'h0);
      issue("LW-inj",    1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b1, 1'b0, 32'h0);
      issue("SB-inj",    1'b1, 2'd0, 1'b0, 32'h14,   32'h00000077, 1'b1, 1'b0, 32'h0);
      issue("LBU-14",    1'b0, 2'd0, 1'b0, 32'h14,   32'h0,        1'b0, 1'b0, 32'h0);
      issue("SW-20",     1'b1, 2'd2, 1'b0, 32'h20,   32'h11223344, 1'b0, 1'b0, 32'h0);

      // Reset pulled during the WRITE cycle, before the memory's falling-edge commit.
      c = cyc;
      exp_busy[c + 1] = 1'b1;
      exp_wr[c + 1]   = {32'd8, 32'hDEADBEEF};
      bus.req_write = 1'b1; bus.req_size = 2'd2; bus.req_signed = 1'b0;
      bus.req_address = 32'h20; bus.req_wdata = 32'hDEADBEEF; bus.req_valid = 1'b1;
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      chk("abort mem_we", 32'(bus.mem_write_enabled), 32'd0);
      chk("abort req_ready", 32'(bus.req_ready), 32'd1);
      chk("abort resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("abort mem_address", bus.mem_address, 32'd0);
      $display("txn %-10s addr=%08h wdata=%08h aborted by reset", "SW-abort", 32'h20, 32'hDEADBEEF);
      @(posedge clock);
      #3 reset_n = 1'b1;
      @(posedge clock); #1;
      issue("LW-20",     1'b0, 2'd2, 1'b0, 32'h20,   32'h0,        1'b0, 1'b1, 32'h11223344);
      repeat (2) begin @(posedge clock); #1; end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
